// File: rtl/fb_fill_engine.sv
// Rectangle fill engine: clips a rectangle to the framebuffer and writes one
// colour word per pixel in row-major order over the sel/wr/ack access port.
module fb_fill_engine #(
   parameter int FB_WIDTH    = 640,
   parameter int FB_HEIGHT   = 480,
   parameter int COORD_WIDTH = 12
) (
   input  logic                   clk,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic [23:0]            base_address_i,
   input  logic [COORD_WIDTH-1:0] x0_i,
   input  logic [COORD_WIDTH-1:0] y0_i,
   input  logic [COORD_WIDTH-1:0] w_i,
   input  logic [COORD_WIDTH-1:0] h_i,
   input  logic [15:0]            color_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   sel_o,
   output logic                   wr_o,
   output logic [3:0]             mask_o,
   output logic [23:0]            address_o,
   output logic [15:0]            data_o,
   input  logic                   ack_i
);
   // state | meaning
   // IDLE  | waiting for start_i, request inputs latched on start
   // SETUP | clip rectangle, compute first row address, detect empty fill
   // REQ   | write in flight, outputs held until ack_i
   // GAP   | idle bus cycle, advance column/row or finish
   // DONE  | one-cycle completion pulse
   typedef enum logic [2:0] {IDLE, SETUP, REQ, GAP, DONE} state_t;

   localparam logic [COORD_WIDTH-1:0] FB_W_C = COORD_WIDTH'(FB_WIDTH);
   localparam logic [COORD_WIDTH-1:0] FB_H_C = COORD_WIDTH'(FB_HEIGHT);
   localparam logic [COORD_WIDTH-1:0] ONE_C  = COORD_WIDTH'(1);
   localparam logic [23:0]            FB_W_A = 24'(FB_WIDTH);

   state_t                 state;
   logic                   sel_q;
   logic [23:0]            base_q;
   logic [23:0]            row_addr;
   logic [15:0]            color_q;
   logic [COORD_WIDTH-1:0] x0_q, y0_q, w_q, h_q;
   logic [COORD_WIDTH-1:0] eff_w, eff_h, col, row;

   logic [COORD_WIDTH-1:0] room_x, room_y, fit_w, fit_h, col_nxt, row_nxt;
   logic [23:0]            origin;
   logic                   empty;

   // Clip terms are only meaningful when the corner lies inside the buffer;
   // the empty check covers the other case before they are used.
   assign room_x  = FB_W_C - x0_q;
   assign room_y  = FB_H_C - y0_q;
   assign fit_w   = (w_q < room_x) ? w_q : room_x;
   assign fit_h   = (h_q < room_y) ? h_q : room_y;
   assign empty   = (x0_q >= FB_W_C) || (y0_q >= FB_H_C) || (w_q == '0) || (h_q == '0);
   assign origin  = base_q + 24'(y0_q) * FB_W_A + 24'(x0_q);
   assign col_nxt = col + ONE_C;
   assign row_nxt = row + ONE_C;

   assign sel_o  = sel_q;
   assign wr_o   = sel_q;
   assign mask_o = 4'hF;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state     <= IDLE;
         sel_q     <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         address_o <= '0;
         data_o    <= '0;
         base_q    <= '0;
         row_addr  <= '0;
         color_q   <= '0;
         x0_q      <= '0;
         y0_q      <= '0;
         w_q       <= '0;
         h_q       <= '0;
         eff_w     <= '0;
         eff_h     <= '0;
         col       <= '0;
         row       <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  base_q  <= base_address_i;
                  x0_q    <= x0_i;
                  y0_q    <= y0_i;
                  w_q     <= w_i;
                  h_q     <= h_i;
                  color_q <= color_i;
                  busy_o  <= 1'b1;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               eff_w    <= fit_w;
               eff_h    <= fit_h;
               col      <= '0;
               row      <= '0;
               row_addr <= origin;
               if (empty) begin
                  done_o <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= DONE;
               end else begin
                  sel_q     <= 1'b1;
                  address_o <= origin;
                  data_o    <= color_q;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (ack_i) begin
                  sel_q <= 1'b0;
                  state <= GAP;
               end
            end
            GAP: begin
               if (col_nxt < eff_w) begin
                  col       <= col_nxt;
                  address_o <= row_addr + 24'(col_nxt);
                  sel_q     <= 1'b1;
                  state     <= REQ;
               end else if (row_nxt < eff_h) begin
                  col       <= '0;
                  row       <= row_nxt;
                  row_addr  <= row_addr + FB_W_A;
                  address_o <= row_addr + FB_W_A;
                  sel_q     <= 1'b1;
                  state     <= REQ;
               end else begin
                  done_o <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fb_fill_engine.sv
// Self-checking bench for fb_fill_engine on a 32x32 framebuffer: directed and
// random fills compared against a pixel-list reference model.
module tb_fb_fill_engine;
   localparam int W = 32;
   localparam int H = 32;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        start_i = 1'b0;
   logic [23:0] base_address_i = '0;
   logic [11:0] x0_i = '0, y0_i = '0, w_i = '0, h_i = '0;
   logic [15:0] color_i = '0;
   logic        busy_o, done_o, sel_o, wr_o;
   logic [3:0]  mask_o;
   logic [23:0] address_o;
   logic [15:0] data_o;
   logic        ack_i = 1'b0;

   int checks = 0;
   int errors = 0;

   // responder configuration (written by the main sequence only)
   int ack_delay  = 0;
   bit ack_always = 1'b0;

   // responder state and write log (written by the responder only)
   int          wait_cnt = 0;
   int          mon_bad = 0;
   logic [23:0] cur_addr = '0;
   logic [15:0] cur_data = '0;
   logic [23:0] wr_addr_q[$];
   logic [15:0] wr_data_q[$];

   fb_fill_engine #(.FB_WIDTH(W), .FB_HEIGHT(H), .COORD_WIDTH(12)) dut (
      .clk(clk), .reset_i(reset_i), .start_i(start_i),
      .base_address_i(base_address_i), .x0_i(x0_i), .y0_i(y0_i),
      .w_i(w_i), .h_i(h_i), .color_i(color_i),
      .busy_o(busy_o), .done_o(done_o), .sel_o(sel_o), .wr_o(wr_o),
      .mask_o(mask_o), .address_o(address_o), .data_o(data_o), .ack_i(ack_i)
   );

   always #5 clk = ~clk;

   // Responder: acks after ack_delay wait cycles, logs each acked write and
   // flags unstable request outputs or bad mask/wr while sel is high.
   always @(negedge clk) begin
      if (sel_o === 1'b1) begin
         if (wait_cnt == 0) begin
            cur_addr = address_o;
            cur_data = data_o;
         end else if (address_o !== cur_addr || data_o !== cur_data) begin
            mon_bad = mon_bad + 1;
         end
         if (mask_o !== 4'hF || wr_o !== 1'b1) mon_bad = mon_bad + 1;
         if (ack_always || wait_cnt == ack_delay) begin
            ack_i = 1'b1;
            wr_addr_q.push_back(address_o);
            wr_data_q.push_back(data_o);
         end else begin
            ack_i = 1'b0;
         end
         wait_cnt = wait_cnt + 1;
      end else begin
         if (wr_o !== 1'b0) mon_bad = mon_bad + 1;
         wait_cnt = 0;
         ack_i    = ack_always;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic run_fill(input string name, input logic [23:0] base, input int x0, input int y0,
                           input int w, input int h, input logic [15:0] colour,
                           input int delay, input bit tied_ack, input bit poke);
      logic [23:0] exp_q[$];
      int n, exp_done_k, done_k, sel_bad, busy_bad, idle_bad, wbase, bad0;
      bit exp_sel;
      for (int y = y0; y < y0 + h && y < H; y++)
         for (int x = x0; x < x0 + w && x < W; x++)
            exp_q.push_back(24'(int'(base) + y * W + x));
      n          = exp_q.size();
      exp_done_k = 2 + n * (delay + 2);
      ack_delay  = delay;
      ack_always = tied_ack;
      wbase      = wr_addr_q.size();
      bad0       = mon_bad;
      done_k     = -1;
      sel_bad    = 0;
      busy_bad   = 0;
      idle_bad   = 0;

      @(negedge clk);
      base_address_i = base;
      x0_i = 12'(x0); y0_i = 12'(y0); w_i = 12'(w); h_i = 12'(h);
      color_i = colour;
      start_i = 1'b1;
      for (int k = 1; k <= 4000; k++) begin
         @(negedge clk);
         if (k == 1) start_i = 1'b0;
         if (poke && k == 3) begin start_i = 1'b1; color_i = ~colour; x0_i = 12'd0; end
         if (poke && k == 4) start_i = 1'b0;
         exp_sel = (n > 0) && (k >= 2) && (k < exp_done_k) && (((k - 2) % (delay + 2)) < delay + 1);
         if (sel_o !== exp_sel) sel_bad++;
         if (busy_o !== (k < exp_done_k)) busy_bad++;
         if (done_o === 1'b1) begin done_k = k; break; end
      end
      check({name, "/done_cycle"}, done_k, exp_done_k);
      check({name, "/sel_pattern"}, sel_bad, 0);
      check({name, "/busy"}, busy_bad, 0);
      check({name, "/write_count"}, wr_addr_q.size() - wbase, n);
      for (int i = 0; i < n && wbase + i < wr_addr_q.size(); i++) begin
         check({name, "/addr"}, wr_addr_q[wbase + i], exp_q[i]);
         check({name, "/data"}, wr_data_q[wbase + i], colour);
      end
      check({name, "/port_stable"}, mon_bad - bad0, 0);
      @(negedge clk);
      check({name, "/done_one_cycle"}, done_o, 1'b0);
      check({name, "/busy_after"}, busy_o, 1'b0);
      if (poke) begin
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy_o !== 1'b0 || sel_o !== 1'b0) idle_bad++;
         end
         check({name, "/no_restart"}, idle_bad, 0);
      end
   endtask

   initial begin
      int sel_k, extra_done;
      repeat (3) @(negedge clk);
      check("reset/sel", sel_o, 1'b0);
      check("reset/wr", wr_o, 1'b0);
      check("reset/busy", busy_o, 1'b0);
      check("reset/done", done_o, 1'b0);
      check("reset/addr", address_o, 24'd0);
      check("reset/data", data_o, 16'd0);
      check("reset/mask", mask_o, 4'hF);
      reset_i = 1'b0;
      @(negedge clk);

      run_fill("basic", 24'd0, 2, 3, 4, 2, 16'hBEEF, 3, 1'b0, 1'b0);
      run_fill("clip", 24'd0, 30, 31, 5, 4, 16'h1234, 1, 1'b0, 1'b0);
      run_fill("clip_base", 24'h001000, 30, 31, 5, 4, 16'h5A5A, 0, 1'b0, 1'b0);
      run_fill("empty_w0", 24'd0, 4, 4, 0, 3, 16'h0F0F, 0, 1'b0, 1'b0);
      run_fill("empty_x32", 24'd0, 32, 0, 4, 4, 16'hF0F0, 0, 1'b0, 1'b0);
      run_fill("empty_y32", 24'd7, 0, 40, 4, 4, 16'hAAAA, 0, 1'b0, 1'b0);
      run_fill("zero_wait", 24'd0, 5, 6, 4, 1, 16'hC0DE, 0, 1'b1, 1'b1);
      run_fill("wrap", 24'hFFFFF0, 0, 0, 3, 2, 16'h7777, 2, 1'b0, 1'b0);

      // reset while a write is held waiting for ack
      ack_delay = 100000;
      ack_always = 1'b0;
      @(negedge clk);
      base_address_i = 24'd0; x0_i = 12'd5; y0_i = 12'd5; w_i = 12'd3; h_i = 12'd3;
      color_i = 16'h9999;
      start_i = 1'b1;
      sel_k = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start_i = 1'b0;
         if (sel_o === 1'b1) begin sel_k = k; break; end
      end
      check("rst_req/sel_seen", sel_k, 2);
      reset_i = 1'b1;
      @(negedge clk);
      check("rst_req/sel", sel_o, 1'b0);
      check("rst_req/wr", wr_o, 1'b0);
      check("rst_req/busy", busy_o, 1'b0);
      check("rst_req/done", done_o, 1'b0);
      check("rst_req/addr", address_o, 24'd0);
      reset_i = 1'b0;
      extra_done = 0;
      repeat (5) begin
         @(negedge clk);
         if (done_o !== 1'b0 || sel_o !== 1'b0) extra_done++;
      end
      check("rst_req/quiet", extra_done, 0);
      run_fill("after_reset", 24'd0, 0, 0, 1, 1, 16'h4321, 1, 1'b0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         run_fill("random", 24'($urandom), int'($urandom_range(0, 36)), int'($urandom_range(0, 36)),
                  int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 16'($urandom),
                  int'($urandom_range(0, 3)), 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
